intersectie_ctrl: RTL and testbench

- Two-road intersection controller: sequences main road (NS) and secondary road (EW) vehicle lights, plus one exclusive pedestrian phase.
- NS is green by default. EW vehicle requests (sensor) and pedestrian requests (buttons) are arbitrated round-robin.
- Sits above the single-crossing semafor block. Drives the lamp outputs directly from a Moore FSM with down-counter timing.

---
 rtl/intersectie_ctrl.sv | 133 +++++++++++++
 tb/tb_intersectie_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/intersectie_ctrl.sv
// Two-road intersection controller (NS main, EW secondary, exclusive pedestrian phase), Moore FSM with down-counter timing.
// Optional macro VERDE_P_CLIPITOR_EN: blinks verde_p during the last 8 cycles of the walk phase.
`timescale 1ns/1ps
module intersectie_ctrl #(
    parameter int WIDTH      = 6,
    parameter int T_VERDE    = 40,
    parameter int T_GALBEN   = 5,
    parameter int T_ROSU_TOT = 3,
    parameter int T_PIETON   = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic buton_p1,
    input  logic buton_p2,
    input  logic senzor_ew,
    output logic rosu_ns,
    output logic galben_ns,
    output logic verde_ns,
    output logic rosu_ew,
    output logic galben_ew,
    output logic verde_ew,
    output logic rosu_p,
    output logic verde_p,
    output logic cerere_p
);
    typedef enum logic [2:0] {
        NS_VERDE, NS_GALBEN, ROSU_1, EW_VERDE, EW_GALBEN, PIETON, ROSU_2
    } state_t;

    localparam logic [WIDTH-1:0] L_VERDE  = WIDTH'(T_VERDE - 1);
    localparam logic [WIDTH-1:0] L_GALBEN = WIDTH'(T_GALBEN - 1);
    localparam logic [WIDTH-1:0] L_ROSU   = WIDTH'(T_ROSU_TOT - 1);
    localparam logic [WIDTH-1:0] L_PIETON = WIDTH'(T_PIETON - 1);

    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_cnt, w_cnt_next, w_dec;
    logic             r_cerere, w_cerere_next;
    logic             r_rr, w_rr_next;
    logic             r_tinta_ew, w_tinta_next;
    logic             w_buton, w_pend_p, w_zero;

    // A press sampled on the exit edge already counts as pending.
    assign w_buton  = (buton_p1 | buton_p2) && (r_state != PIETON);
    assign w_pend_p = r_cerere | w_buton;
    assign w_zero   = (r_cnt == '0);
    assign w_dec    = w_zero ? '0 : r_cnt - WIDTH'(1);

    always_comb begin
        w_next       = r_state;
        w_rr_next    = r_rr;
        w_tinta_next = r_tinta_ew;
        case (r_state)
            NS_VERDE: begin
                if (w_zero && (senzor_ew | w_pend_p)) begin
                    w_next = NS_GALBEN;
                    if (senzor_ew && w_pend_p) begin
                        w_tinta_next = r_rr;
                        w_rr_next    = ~r_rr;
                    end else begin
                        w_tinta_next = senzor_ew;
                    end
                end
            end
            NS_GALBEN: if (w_zero) w_next = ROSU_1;
            ROSU_1:    if (w_zero) w_next = r_tinta_ew ? EW_VERDE : PIETON;
            EW_VERDE:  if (w_zero) w_next = EW_GALBEN;
            EW_GALBEN: if (w_zero) w_next = ROSU_2;
            PIETON:    if (w_zero) w_next = ROSU_2;
            ROSU_2:    if (w_zero) w_next = NS_VERDE;
            default:   w_next = NS_VERDE;
        endcase

        w_cnt_next = w_dec;
        if (w_next != r_state) begin
            case (w_next)
                NS_VERDE:           w_cnt_next = L_VERDE;
                EW_VERDE:           w_cnt_next = L_VERDE;
                NS_GALBEN:          w_cnt_next = L_GALBEN;
                EW_GALBEN:          w_cnt_next = L_GALBEN;
                PIETON:             w_cnt_next = L_PIETON;
                default:            w_cnt_next = L_ROSU;
            endcase
        end

        w_cerere_next = r_cerere | w_buton;
        if (w_next == PIETON && r_state != PIETON) w_cerere_next = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= NS_VERDE;
            r_cnt      <= L_VERDE;
            r_cerere   <= 1'b0;
            r_rr       <= 1'b0;
            r_tinta_ew <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_cnt      <= w_cnt_next;
            r_cerere   <= w_cerere_next;
            r_rr       <= w_rr_next;
            r_tinta_ew <= w_tinta_next;
        end
    end

    always_comb begin
        rosu_ns   = 1'b0;
        galben_ns = 1'b0;
        verde_ns  = 1'b0;
        rosu_ew   = 1'b0;
        galben_ew = 1'b0;
        verde_ew  = 1'b0;
        rosu_p    = 1'b1;
        verde_p   = 1'b0;
        cerere_p  = r_cerere;
        case (r_state)
            NS_VERDE:  begin verde_ns  = 1'b1; rosu_ew = 1'b1; end
            NS_GALBEN: begin galben_ns = 1'b1; rosu_ew = 1'b1; end
            EW_VERDE:  begin verde_ew  = 1'b1; rosu_ns = 1'b1; end
            EW_GALBEN: begin galben_ew = 1'b1; rosu_ns = 1'b1; end
            PIETON: begin
                rosu_ns = 1'b1;
                rosu_ew = 1'b1;
                rosu_p  = 1'b0;
`ifdef VERDE_P_CLIPITOR_EN
                verde_p = (r_cnt < WIDTH'(8)) ? r_cnt[1] : 1'b1;
`else
                verde_p = 1'b1;
`endif
            end
            default:   begin rosu_ns = 1'b1; rosu_ew = 1'b1; end
        endcase
    end
endmodule

// File: tb/tb_intersectie_ctrl.sv
// Self-checking bench for intersectie_ctrl: directed scenarios plus random traffic against a segment-queue reference model.
`timescale 1ns/1ps
module tb_intersectie_ctrl;
    localparam int TV = 40, TG = 5, TR = 3, TP = 20;
    // Lamp vector order: {rosu_ns,galben_ns,verde_ns,rosu_ew,galben_ew,verde_ew,rosu_p,verde_p}
    localparam logic [7:0] NSG  = 8'b001_100_10;
    localparam logic [7:0] NSY  = 8'b010_100_10;
    localparam logic [7:0] ALLR = 8'b100_100_10;
    localparam logic [7:0] EWG  = 8'b100_001_10;
    localparam logic [7:0] EWY  = 8'b100_010_10;
    localparam logic [7:0] WALK = 8'b100_100_01;

    logic clk = 1'b0, rst = 1'b1;
    logic buton_p1 = 1'b0, buton_p2 = 1'b0, senzor_ew = 1'b0;
    logic rosu_ns, galben_ns, verde_ns, rosu_ew, galben_ew, verde_ew, rosu_p, verde_p, cerere_p;
    logic [7:0] dut_l;
    int checks = 0, errors = 0;

    // Reference model: NS green is the idle phase; every NS exit queues its whole cycle of (lamps, duration) segments.
    logic [7:0] mq_lamp[$];
    int         mq_rem[$];
    int         m_ns;
    bit         m_ped, m_rr;

    intersectie_ctrl dut (
        .clk(clk), .rst(rst), .buton_p1(buton_p1), .buton_p2(buton_p2), .senzor_ew(senzor_ew),
        .rosu_ns(rosu_ns), .galben_ns(galben_ns), .verde_ns(verde_ns),
        .rosu_ew(rosu_ew), .galben_ew(galben_ew), .verde_ew(verde_ew),
        .rosu_p(rosu_p), .verde_p(verde_p), .cerere_p(cerere_p)
    );

    always #5 clk = ~clk;
    assign dut_l = {rosu_ns, galben_ns, verde_ns, rosu_ew, galben_ew, verde_ew, rosu_p, verde_p};

    function automatic logic [7:0] m_lamp();
        logic [7:0] l;
        if (mq_lamp.size() == 0) return NSG;
        l = mq_lamp[0];
`ifdef VERDE_P_CLIPITOR_EN
        if (l == WALK && mq_rem[0] - 1 < 8) l[0] = ((mq_rem[0] - 1) / 2) % 2 == 1;
`endif
        return l;
    endfunction

    task automatic push_seg(input logic [7:0] l, input int n);
        mq_lamp.push_back(l);
        mq_rem.push_back(n);
    endtask

    task automatic m_edge(input logic r, input logic b1, input logic b2, input logic s);
        bit b, in_walk, now_walk, ped, go_walk;
        if (r) begin
            mq_lamp.delete(); mq_rem.delete();
            m_ns = 1; m_ped = 0; m_rr = 0;
            return;
        end
        b = b1 | b2;
        in_walk = mq_lamp.size() > 0 && mq_lamp[0] == WALK;
        if (mq_lamp.size() == 0) begin
            ped = m_ped | b;
            if (m_ns >= TV && (s || ped)) begin
                go_walk = ped && (!s || !m_rr);
                if (ped && s) m_rr = !m_rr;
                push_seg(NSY, TG); push_seg(ALLR, TR);
                if (go_walk) begin
                    push_seg(WALK, TP); push_seg(ALLR, TR);
                end else begin
                    push_seg(EWG, TV); push_seg(EWY, TG); push_seg(ALLR, TR);
                end
            end else m_ns++;
        end else begin
            mq_rem[0] = mq_rem[0] - 1;
            if (mq_rem[0] == 0) begin
                void'(mq_lamp.pop_front());
                void'(mq_rem.pop_front());
                if (mq_lamp.size() == 0) m_ns = 1;
            end
        end
        now_walk = mq_lamp.size() > 0 && mq_lamp[0] == WALK;
        if (!in_walk && b) m_ped = 1;
        if (now_walk && !in_walk) m_ped = 0;
    endtask

    // Inputs are held through the next rising edge; outputs are sampled 1ns after it.
    task automatic tick(input logic r, input logic b1, input logic b2, input logic s);
        rst = r; buton_p1 = b1; buton_p2 = b2; senzor_ew = s;
        @(posedge clk);
        m_edge(r, b1, b2, s);
        #1;
    endtask

    task automatic test_reset();
        tick(1, 0, 0, 0);
        tick(1, 1, 1, 1);
        checks++;
        if (dut_l !== NSG || cerere_p !== 1'b0) begin
            errors++;
            $display("FAIL reset lamps=%b cerere=%b required lamps=%b cerere=0", dut_l, cerere_p, NSG);
        end
    endtask

    task automatic test_idle();
        tick(1, 0, 0, 0);
        for (int i = 0; i < 200; i++) begin
            tick(0, 0, 0, 0);
            checks++;
            if (dut_l !== NSG || cerere_p !== 1'b0) begin
                errors++;
                $display("FAIL idle cyc=%0d lamps=%b cerere=%b required %b 0", i + 1, dut_l, cerere_p, NSG);
            end
        end
    endtask

    task automatic test_ew();
        int n_ewg = 0;
        tick(1, 0, 0, 0);
        for (int i = 0; i < 190; i++) begin
            tick(0, 0, 0, i >= 5);
            if (i < 96 && dut_l === EWG) n_ewg++;
            checks++;
            if (dut_l !== m_lamp() || cerere_p !== m_ped) begin
                errors++;
                $display("FAIL ew cyc=%0d lamps=%b cerere=%b required %b %b", i + 1, dut_l, cerere_p, m_lamp(), m_ped);
            end
        end
        checks++;
        if (n_ewg != TV) begin
            errors++;
            $display("FAIL ew_green_len got=%0d required=%0d", n_ewg, TV);
        end
    endtask

    task automatic test_ped_button();
        logic [19:0] pat = '0, exp_pat;
`ifdef VERDE_P_CLIPITOR_EN
        exp_pat = 20'hFFFCC;
`else
        exp_pat = 20'hFFFFF;
`endif
        tick(1, 0, 0, 0);
        for (int i = 0; i < 60; i++) tick(0, 0, 0, 0);
        tick(0, 1, 0, 0);
        checks++;
        if (galben_ns !== 1'b1 || cerere_p !== 1'b1) begin
            errors++;
            $display("FAIL ped_exit cyc=61 galben_ns=%b cerere=%b required 1 1", galben_ns, cerere_p);
        end
        for (int k = 1; k <= 40; k++) begin
            tick(0, 0, 0, 0);
            if (k >= 8 && k <= 27) pat = {pat[18:0], verde_p};
            checks++;
            if (dut_l !== m_lamp() || cerere_p !== m_ped) begin
                errors++;
                $display("FAIL ped cyc=%0d lamps=%b cerere=%b required %b %b", 61 + k, dut_l, cerere_p, m_lamp(), m_ped);
            end
        end
        checks++;
        if (pat !== exp_pat) begin
            errors++;
            $display("FAIL walk_pattern got=%b required=%b", pat, exp_pat);
        end
    endtask

    task automatic test_both_rr();
        logic [7:0] served[$];
        logic [7:0] prev = NSG;
        tick(1, 0, 0, 0);
        for (int i = 0; i < 240; i++) begin
            tick(0, i == 90, i == 20, i >= 10);
            if ((dut_l === WALK || dut_l === EWG) && prev !== dut_l) served.push_back(dut_l);
            prev = dut_l;
            checks++;
            if (dut_l !== m_lamp() || cerere_p !== m_ped) begin
                errors++;
                $display("FAIL rr cyc=%0d lamps=%b cerere=%b required %b %b", i + 1, dut_l, cerere_p, m_lamp(), m_ped);
            end
        end
        checks++;
        if (served.size() != 3 || served[0] !== WALK || served[1] !== EWG || served[2] !== WALK) begin
            errors++;
            $display("FAIL rr_order served_count=%0d required 3 phases walk,ew,walk", served.size());
        end
    endtask

    task automatic test_ped_ignored();
        tick(1, 0, 0, 0);
        for (int i = 0; i < 150; i++) begin
            tick(0, i == 10, i == 55, 0);
            checks++;
            if (dut_l !== m_lamp() || cerere_p !== m_ped) begin
                errors++;
                $display("FAIL ign cyc=%0d lamps=%b cerere=%b required %b %b", i + 1, dut_l, cerere_p, m_lamp(), m_ped);
            end
        end
        checks++;
        if (dut_l !== NSG || cerere_p !== 1'b0) begin
            errors++;
            $display("FAIL ign_hold lamps=%b cerere=%b required %b 0", dut_l, cerere_p, NSG);
        end
    endtask

    task automatic test_mid_reset();
        int n_g = 0;
        bit run = 1;
        tick(1, 0, 0, 0);
        for (int i = 0; i < 60; i++) tick(0, i == 50, 0, 1);
        tick(1, 0, 0, 1);
        checks++;
        if (dut_l !== NSG || cerere_p !== 1'b0) begin
            errors++;
            $display("FAIL midrst lamps=%b cerere=%b required %b 0", dut_l, cerere_p, NSG);
        end
        n_g = 1;
        for (int i = 0; i < 60; i++) begin
            tick(0, 0, 0, 1);
            if (run && verde_ns === 1'b1) n_g++; else run = 0;
            checks++;
            if (dut_l !== m_lamp() || cerere_p !== m_ped) begin
                errors++;
                $display("FAIL midrst cyc=%0d lamps=%b cerere=%b required %b %b", i, dut_l, cerere_p, m_lamp(), m_ped);
            end
        end
        checks++;
        if (n_g != TV) begin
            errors++;
            $display("FAIL midrst_green_len got=%0d required=%0d", n_g, TV);
        end
    endtask

    task automatic test_random();
        logic s = 0;
        tick(1, 0, 0, 0);
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 49) == 0) s = ~s;
            tick($urandom_range(0, 1499) == 0, $urandom_range(0, 39) == 0, $urandom_range(0, 39) == 0, s);
            checks++;
            if (dut_l !== m_lamp() || cerere_p !== m_ped) begin
                errors++;
                $display("FAIL rand cyc=%0d lamps=%b cerere=%b required %b %b", i, dut_l, cerere_p, m_lamp(), m_ped);
            end
        end
    endtask

    initial begin
        m_ns = 1; m_ped = 0; m_rr = 0;
        test_reset();
        test_idle();
        test_ew();
        test_ped_button();
        test_both_rr();
        test_ped_ignored();
        test_mid_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
